store_buffer: RTL
=================

# store_buffer

Store-side counterpart to the load pipe: accepts issued stores from the reservation station, computes and aligns address/data, reports execution completion to the ROB, holds each store until the ROB commits it, then drains committed stores in program order into the data-memory write port. Sits between the store RS, the ROB commit bus and the 1024-word data memory. Also exposes a combinational address-conflict check so the load pipe can stall loads that overlap pending stores.

## Interface
- DEPTH, 8: entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid_i  in  1  store issue request.
- ready_o  out  1  buffer can accept; equals (count < DEPTH).
- rs1_val_i  in  32  base address.
- imm_i  in  32  offset.
- rs2_val_i  in  32  store data.
- size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and flagged as exception.
- rob_tag_i  in  6  ROB tag of store.
- done_valid_o  out  1  one-cycle completion pulse to ROB.
- done_rob_tag_o  out  6  tag of completed store.
- done_exc_o  out  1  store misaligned or illegal size.
- commit_valid_i  in  1  ROB retires the oldest uncommitted store.
- commit_rob_tag_i  in  6  tag of that store, for checking.
- commit_err_o  out  1  one-cycle pulse: commit with no uncommitted entry or tag mismatch.
- flush_i  in  1  discard all uncommitted entries.
- mem_we_o  out  1  write request.
- mem_gnt_i  in  1  memory accepts write this cycle.
- mem_addr_o  out  10  word index.
- mem_wdata_o  out  32  lane-aligned data.
- mem_wstrb_o  out  4  byte enables.
- ld_addr_i  in  32  byte address of a probing load.
- ld_conflict_o  out  1  some valid entry writes the word ld_addr_i[11:2].
- empty_o  out  1  no valid entries.

## Operation
- Circular buffer; three pointers head (oldest), cmt (oldest uncommitted), tail (next free); each log2(DEPTH)+1 bits, extra MSB is the wrap bit. Full when pointers are equal except MSB; empty when head == tail.
- Accept on valid_i && ready_o: addr = rs1_val_i + imm_i (mod 2^32). Entry stores word index addr[11:2], aligned data, strobe, tag and exc; tail advances.
- Alignment: byte → data {4{d[7:0]}}, strb 4'b0001 << addr[1:0]. Half → {2{d[15:0]}}, 4'b0011 << {addr[1],1'b0}. Word → d, 4'b1111.
- exc = (half && addr[0]) || (word && addr[1:0] != 0) || size_i == 3. exc entries are never written to memory. A commit of an exc entry advances cmt; drain then drops it without asserting mem_we_o, one cycle per dropped entry.
- Commit: when cmt != tail and commit_rob_tag_i equals the tag at cmt, cmt advances. Otherwise the entry is unchanged and commit_err_o pulses.
- Drain: mem_we_o = (head != cmt) && !exc[head]. head advances when mem_we_o && mem_gnt_i, or unconditionally when head != cmt && exc[head].
- Flush: tail ← cmt after the same-cycle commit is applied, so a store committing in the flush cycle survives. An incoming store in the flush cycle is dropped. Committed entries keep draining.
- ld_conflict_o: OR over all valid entries (head ≤ i < tail, exc clear) of word-index match. Strobe overlap is not checked.
- Accept, commit and drain may all happen in one cycle.

## Timing
- Reset: head = cmt = tail = 0. Outputs: ready_o = 1, empty_o = 1, done_valid_o = 0, done_exc_o = 0, done_rob_tag_o = 0, commit_err_o = 0, mem_we_o = 0, ld_conflict_o = 0.
- Reset asserted mid-operation discards all entries, including committed ones.
- done_* outputs are registered: a store accepted at edge N pulses done_valid_o for the cycle after N.
- commit_err_o is registered, one cycle after the offending commit.
- Earliest write: commit at edge N → mem_we_o high in the cycle after N, address/data from the head entry. With continuous mem_gnt_i, throughput is 1 store/cycle.
- ready_o uses the registered count only; a same-cycle drain does not free a slot for same-cycle accept.
- mem_* outputs and ld_conflict_o are combinational from registered state (ld_conflict_o also from ld_addr_i). mem_* hold stable while mem_we_o && !mem_gnt_i.

## Structure
- lsu_pkg holds mem_size_t (BYTE/HALF/WORD), store_entry_t {widx[9:0], wdata[31:0], wstrb[3:0], rob_tag[5:0], exc}, and DMEM_WORDS = 1024. It is shared with the load pipe.
- Sub-module store_align: combinational; maps addr[1:0], size and data to wdata, wstrb and exc. It is reused by future sub-word load extraction.

## Test plan
- Store word 0xDEADBEEF to address 0x10, tag 5; commit tag 5 with mem_gnt_i = 1 → done pulse tag 5, then mem_we_o with addr 4, wstrb 1111, wdata 0xDEADBEEF.
- sb 0xAB at 0x103 → wstrb 1000, wdata 0xABABABAB. sh 0x1234 at 0x102 → wstrb 1100. sh at 0x101 → done_exc_o = 1 and no memory write after commit.
- Issue DEPTH stores → ready_o = 0. Accept while draining in the same cycle → ready_o stays 0 that cycle. Pointer wrap after 3×DEPTH stores → all writes in order, none lost.
- Accept 4 stores, commit 2, assert flush_i together with the commit of the 3rd → exactly 3 memory writes; tail == cmt.
- Commit with a wrong tag, or commit while empty → commit_err_o pulses and no pointer moves.
- Pending store to 0x40 → ld_addr_i 0x42 gives ld_conflict_o = 1; 0x44 gives 0. After the drain with mem_gnt_i held low for 3 cycles, mem_* stay stable and the conflict clears after the grant.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Used by the store buffer and the load pipe: access-size encoding,
// the store buffer entry layout and the data-memory geometry.
package lsu_pkg;

    localparam int DMEM_WORDS = 1024;
    localparam int DMEM_IDX_W = $clog2(DMEM_WORDS);

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic [DMEM_IDX_W-1:0] widx;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
        logic [5:0]            rob_tag;
        logic                  exc;
    } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Store lane alignment.
// Replicates store data across the lanes of a 32-bit word, builds the byte
// strobe from the low address bits and flags misaligned or illegal accesses.
// Ports:
//   addr_lo_i  low two bits of the byte address
//   size_i     access size (BYTE/HALF/WORD; 3 is illegal)
//   data_i     raw store data from the register file
//   wdata_o    lane-replicated write data
//   wstrb_o    byte enables
//   exc_o      misaligned access or illegal size
module store_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        exc_o
);

    always_comb begin
        wdata_o = data_i;
        wstrb_o = 4'b0000;
        exc_o   = 1'b0;
        case (size_i)
            BYTE: begin
                wdata_o = {4{data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            HALF: begin
                wdata_o = {2{data_i[15:0]}};
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                exc_o   = addr_lo_i[0];
            end
            WORD: begin
                wstrb_o = 4'b1111;
                exc_o   = |addr_lo_i;
            end
            default: begin
                exc_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer.
// Holds issued stores until the ROB commits them, then drains committed
// stores in program order to the data-memory write port. Also provides a
// word-granular address conflict probe for the load pipe.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   valid_i/ready_o, rs1_val_i, imm_i,
//   rs2_val_i, size_i, rob_tag_i       store issue from the RS
//   done_valid_o/_rob_tag_o/_exc_o     registered completion report to ROB
//   commit_valid_i, commit_rob_tag_i   ROB commit of the oldest uncommitted store
//   commit_err_o                       registered bad-commit pulse
//   flush_i                            discard uncommitted entries
//   mem_we_o, mem_gnt_i, mem_addr_o,
//   mem_wdata_o, mem_wstrb_o           data-memory write port
//   ld_addr_i, ld_conflict_o           load conflict probe
//   empty_o                            no valid entries
module store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           rs1_val_i,
    input  logic [31:0]           imm_i,
    input  logic [31:0]           rs2_val_i,
    input  logic [1:0]            size_i,
    input  logic [5:0]            rob_tag_i,
    output logic                  done_valid_o,
    output logic [5:0]            done_rob_tag_o,
    output logic                  done_exc_o,
    input  logic                  commit_valid_i,
    input  logic [5:0]            commit_rob_tag_i,
    output logic                  commit_err_o,
    input  logic                  flush_i,
    output logic                  mem_we_o,
    input  logic                  mem_gnt_i,
    output logic [DMEM_IDX_W-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_wstrb_o,
    input  logic [31:0]           ld_addr_i,
    output logic                  ld_conflict_o,
    output logic                  empty_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] cmt_q,  cmt_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          done_valid_q, done_valid_d;
    logic [5:0]    done_tag_q,   done_tag_d;
    logic          done_exc_q,   done_exc_d;
    logic          commit_err_q, commit_err_d;

    store_entry_t  entries_q [DEPTH];
    store_entry_t  entries_d [DEPTH];

    logic [PW-1:0] count;
    logic [31:0]   addr;
    logic [31:0]   al_wdata;
    logic [3:0]    al_wstrb;
    logic          al_exc;
    logic          accept;
    logic          commit_ok;
    logic          has_committed;
    store_entry_t  head_ent;
    logic          drain_adv;
    logic [IW-1:0] off;
    logic          conflict;
    logic          unused_addr_bits;

    assign addr  = rs1_val_i + imm_i;
    assign count = tail_q - head_q;

    store_align u_align (
        .addr_lo_i (addr[1:0]),
        .size_i    (size_i),
        .data_i    (rs2_val_i),
        .wdata_o   (al_wdata),
        .wstrb_o   (al_wstrb),
        .exc_o     (al_exc)
    );

    assign ready_o       = (count < DEPTH_P);
    assign empty_o       = (head_q == tail_q);
    // A store arriving together with a flush is discarded.
    assign accept        = valid_i && ready_o && !flush_i;
    assign commit_ok     = commit_valid_i && (cmt_q != tail_q)
                           && (entries_q[cmt_q[IW-1:0]].rob_tag == commit_rob_tag_i);
    assign has_committed = (head_q != cmt_q);
    assign head_ent      = entries_q[head_q[IW-1:0]];

    assign mem_we_o    = has_committed && !head_ent.exc;
    assign mem_addr_o  = head_ent.widx;
    assign mem_wdata_o = head_ent.wdata;
    assign mem_wstrb_o = head_ent.wstrb;
    // Faulting entries are retired from the head without touching memory.
    assign drain_adv   = has_committed && (head_ent.exc || mem_gnt_i);

    always_comb begin
        cmt_d = cmt_q;
        if (commit_ok) begin
            cmt_d = cmt_q + PW'(1);
        end
        tail_d = tail_q;
        if (flush_i) begin
            tail_d = cmt_d;
        end else if (accept) begin
            tail_d = tail_q + PW'(1);
        end
        head_d = head_q;
        if (drain_adv) begin
            head_d = head_q + PW'(1);
        end
        done_valid_d = accept;
        done_tag_d   = accept ? rob_tag_i : 6'd0;
        done_exc_d   = accept && al_exc;
        commit_err_d = commit_valid_i && !commit_ok;
    end

    always_comb begin
        entries_d = entries_q;
        if (accept) begin
            entries_d[tail_q[IW-1:0]].widx    = addr[DMEM_IDX_W+1:2];
            entries_d[tail_q[IW-1:0]].wdata   = al_wdata;
            entries_d[tail_q[IW-1:0]].wstrb   = al_wstrb;
            entries_d[tail_q[IW-1:0]].rob_tag = rob_tag_i;
            entries_d[tail_q[IW-1:0]].exc     = al_exc;
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        conflict = 1'b0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = IW'(i) - head_q[IW-1:0];
            if (({1'b0, off} < count) && !entries_q[i].exc
                && (entries_q[i].widx == ld_addr_i[DMEM_IDX_W+1:2])) begin
                conflict = 1'b1;
            end
        end
    end
    assign ld_conflict_o = conflict;

    assign unused_addr_bits = ^{addr[31:DMEM_IDX_W+2], ld_addr_i[31:DMEM_IDX_W+2],
                                ld_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q       <= '0;
            cmt_q        <= '0;
            tail_q       <= '0;
            done_valid_q <= 1'b0;
            done_tag_q   <= '0;
            done_exc_q   <= 1'b0;
            commit_err_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            cmt_q        <= cmt_d;
            tail_q       <= tail_d;
            done_valid_q <= done_valid_d;
            done_tag_q   <= done_tag_d;
            done_exc_q   <= done_exc_d;
            commit_err_q <= commit_err_d;
        end
    end

    // Entry payload needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign done_valid_o   = done_valid_q;
    assign done_rob_tag_o = done_tag_q;
    assign done_exc_o     = done_exc_q;
    assign commit_err_o   = commit_err_q;

endmodule
